sprite_scheduler: RTL and testbench

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

---
 rtl/sprite_sched_pkg.sv | 31 +++
 rtl/sprite_scheduler_if.sv | 36 +++
 rtl/frame_tick_gen.sv | 30 +++
 rtl/sprite_scheduler.sv | 152 +++++++++++++++
 tb/tb_sprite_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_sched_pkg.sv
// Shared state encoding, pixel field widths and the mask-search helper
// used by the sprite scheduler.
package sprite_sched_pkg;

    localparam int X_W         = 9;
    localparam int Y_W         = 8;
    localparam int C_W         = 3;
    localparam int MAX_SPRITES = 8;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        GAP,
        DRAW,
        NEXT
    } sched_state_e;

    // Lowest set mask bit at or above start; bit 3 of the result flags a hit.
    function automatic logic [3:0] next_set_bit(input logic [MAX_SPRITES-1:0] mask,
                                                input int start);
        logic [3:0] res;
        res = '0;
        for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// Sprite engine / VGA port bundle between the scheduler (slave) and the
// sprite engines plus VGA writer (master).
interface sprite_scheduler_if #(
    parameter int NUM_SPRITES = 4
);
    import sprite_sched_pkg::*;

    logic [NUM_SPRITES-1:0]     enable;
    logic [NUM_SPRITES-1:0]     finish;
    logic [X_W*NUM_SPRITES-1:0] sprite_x;
    logic [Y_W*NUM_SPRITES-1:0] sprite_y;
    logic [C_W*NUM_SPRITES-1:0] sprite_colour;

    logic [NUM_SPRITES-1:0]     draw_signal;
    logic [NUM_SPRITES-1:0]     erase_signal;
    logic [X_W-1:0]             x;
    logic [Y_W-1:0]             y;
    logic [C_W-1:0]             colour;
    logic                       plot;
    logic                       frame_done;
    logic                       timeout_err;
    logic                       overrun;

    modport master (
        output enable, finish, sprite_x, sprite_y, sprite_colour,
        input  draw_signal, erase_signal, x, y, colour, plot,
               frame_done, timeout_err, overrun
    );

    modport slave (
        input  enable, finish, sprite_x, sprite_y, sprite_colour,
        output draw_signal, erase_signal, x, y, colour, plot,
               frame_done, timeout_err, overrun
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running frame counter: counts 0..FRAME_CYCLES-1 and flags the wrap
// cycle with a single-cycle tick.
module frame_tick_gen #(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Time-multiplexes one VGA write port across several sprite engines: once per
// frame tick every enabled sprite gets an erase phase then a draw phase.
module sprite_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_SPRITES  = 4,
    parameter int FRAME_CYCLES = 833333,
    parameter int TIMEOUT      = 63
) (
    input  logic clk,
    input  logic reset,
    sprite_scheduler_if.slave bus
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_SPRITES-1:0] mask_q, mask_d;
    logic [WD_W-1:0]        watchdog_q, watchdog_d, watchdog_inc;
    logic [NUM_SPRITES-1:0] draw_q, draw_d;
    logic [NUM_SPRITES-1:0] erase_q, erase_d;
    logic                   plot_q, plot_d;
    logic                   frame_done_q, frame_done_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   overrun_q, overrun_d;

    logic                   tick;
    logic                   granted_finish;
    logic                   phase_timeout;
    logic [MAX_SPRITES-1:0] search_mask;
    logic [3:0]             hit;

    frame_tick_gen #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        mask_d         = mask_q;
        watchdog_d     = watchdog_q;
        frame_done_d   = 1'b0;
        timeout_err_d  = timeout_err_q;
        search_mask    = '0;
        hit            = '0;
        watchdog_inc   = watchdog_q + 1'b1;
        granted_finish = bus.finish[idx_q];
        phase_timeout  = (watchdog_inc == WD_LIMIT);
        // A tick that lands mid-frame is dropped; only the sticky flag records it.
        overrun_d      = overrun_q | (tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                watchdog_d = '0;
                if (tick) begin
                    if (|bus.enable) begin
                        search_mask[NUM_SPRITES-1:0] = bus.enable;
                        hit     = next_set_bit(search_mask, 0);
                        mask_d  = bus.enable;
                        idx_d   = IDX_W'(hit[2:0]);
                        state_d = ERASE;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            ERASE, DRAW: begin
                watchdog_d = watchdog_inc;
                // Finish wins over a coincident timeout, so no error in that case.
                if (granted_finish || phase_timeout) begin
                    state_d       = (state_q == ERASE) ? GAP : NEXT;
                    timeout_err_d = timeout_err_q | ~granted_finish;
                end
            end
            GAP: begin
                watchdog_d = '0;
                state_d    = DRAW;
            end
            NEXT: begin
                watchdog_d = '0;
                search_mask[NUM_SPRITES-1:0] = mask_q;
                hit = next_set_bit(search_mask, int'(idx_q) + 1);
                if (hit[3]) begin
                    idx_d   = IDX_W'(hit[2:0]);
                    state_d = ERASE;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        erase_d = (state_d == ERASE) ? (NUM_SPRITES'(1) << idx_d) : '0;
        draw_d  = (state_d == DRAW)  ? (NUM_SPRITES'(1) << idx_d) : '0;
        plot_d  = (state_d == ERASE) || (state_d == DRAW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            mask_q        <= '0;
            watchdog_q    <= '0;
            draw_q        <= '0;
            erase_q       <= '0;
            plot_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mask_q        <= mask_d;
            watchdog_q    <= watchdog_d;
            draw_q        <= draw_d;
            erase_q       <= erase_d;
            plot_q        <= plot_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        bus.x      = '0;
        bus.y      = '0;
        bus.colour = '0;
        if (plot_q) begin
            bus.x      = bus.sprite_x[int'(idx_q)*X_W +: X_W];
            bus.y      = bus.sprite_y[int'(idx_q)*Y_W +: Y_W];
            bus.colour = bus.sprite_colour[int'(idx_q)*C_W +: C_W];
        end
    end

    assign bus.draw_signal  = draw_q;
    assign bus.erase_signal = erase_q;
    assign bus.plot         = plot_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: a behavioural sprite-engine model
// answers requests, and a per-cycle expected trace is built from the frame rules.
module tb_sprite_scheduler;
    import sprite_sched_pkg::*;

    localparam int NS    = 4;
    localparam int FC    = 100;
    localparam int TO    = 63;
    localparam int NEVER = 1000;

    typedef struct packed {
        logic [NS-1:0]  erase;
        logic [NS-1:0]  draw;
        logic           plot;
        logic           fd;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } pix_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sprite_scheduler_if #(.NUM_SPRITES(NS)) bus ();

    sprite_scheduler #(
        .NUM_SPRITES (NS),
        .FRAME_CYCLES(FC),
        .TIMEOUT     (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc;
    int fin_delay [NS];
    int req_cnt   [NS];
    logic [X_W-1:0] sx [NS];
    logic [Y_W-1:0] sy [NS];
    logic [C_W-1:0] sc [NS];
    bit   exp_timeout;
    bit   exp_overrun;
    pix_t exp_q [$];

    // Cycles since reset release; the tick falls where this is FC-1 modulo FC.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic pix_t observe();
        pix_t o;
        o.erase = bus.erase_signal;
        o.draw  = bus.draw_signal;
        o.plot  = bus.plot;
        o.fd    = bus.frame_done;
        o.x     = bus.x;
        o.y     = bus.y;
        o.c     = bus.colour;
        return o;
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < NS; i++) begin
            bus.sprite_x[i*X_W +: X_W]      = sx[i];
            bus.sprite_y[i*Y_W +: Y_W]      = sy[i];
            bus.sprite_colour[i*C_W +: C_W] = sc[i];
        end
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < NS; i++) begin
            sx[i] = X_W'($urandom);
            sy[i] = Y_W'($urandom);
            sc[i] = C_W'($urandom);
        end
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < NS; i++) fin_delay[i] = d;
    endtask

    // Sprite engines: each raises finish in the fin_delay-th cycle of its request;
    // engines without a request drive random finish noise.
    task automatic engine_step();
        logic [NS-1:0] req;
        req = bus.erase_signal | bus.draw_signal;
        for (int i = 0; i < NS; i++) begin
            if (req[i]) begin
                req_cnt[i]++;
                bus.finish[i] = (req_cnt[i] >= fin_delay[i]);
            end else begin
                req_cnt[i]    = 0;
                bus.finish[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // Expected trace for the cycles after a tick: per enabled sprite in ascending
    // order, an erase run, one quiet cycle, a draw run, one quiet cycle; then frame_done.
    task automatic build_model(input logic [NS-1:0] mask);
        pix_t e;
        int   ph;
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            if (mask[i]) begin
                ph = (fin_delay[i] < TO) ? fin_delay[i] : TO;
                if (fin_delay[i] > TO) exp_timeout = 1'b1;
                for (int pass = 0; pass < 2; pass++) begin
                    repeat (ph) begin
                        e       = '0;
                        e.erase = (pass == 0) ? (NS'(1) << i) : '0;
                        e.draw  = (pass == 1) ? (NS'(1) << i) : '0;
                        e.plot  = 1'b1;
                        e.x     = sx[i];
                        e.y     = sy[i];
                        e.c     = sc[i];
                        exp_q.push_back(e);
                    end
                    exp_q.push_back('0);
                end
            end
        end
        e    = '0;
        e.fd = 1'b1;
        exp_q.push_back(e);
        if (exp_q.size() - 1 >= FC) exp_overrun = 1'b1;
    endtask

    task automatic wait_tick();
        pix_t obs;
        for (int g = 0; g <= FC + 1; g++) begin
            if ((cyc % FC) == FC - 1) return;
            @(posedge clk);
            #1;
            engine_step();
            obs = observe();
            checks++;
            if (obs !== '0) $display("[TB] FAIL idle_quiet cyc=%0d got=%h want=0", cyc, obs);
            else passed++;
        end
        checks++;
        $display("[TB] FAIL tick_wait_timeout cyc=%0d got=no_tick want=tick", cyc);
    endtask

    task automatic run_frame(input string name, input logic [NS-1:0] mask,
                             input logic [NS-1:0] mid_en, input int mid_at,
                             input int exp_lat);
        pix_t obs;
        int   lat;
        int   want_lat;
        bus.enable = mask;
        drive_fields();
        build_model(mask);
        want_lat = (exp_lat < 0) ? exp_q.size() : exp_lat;
        wait_tick();
        lat = -1;
        for (int t = 1; t <= exp_q.size(); t++) begin
            @(posedge clk);
            #1;
            engine_step();
            if (t == mid_at) bus.enable = mid_en;
            obs = observe();
            checks++;
            if (obs !== exp_q[t-1])
                $display("[TB] FAIL %s_cycle t=%0d got=%h want=%h", name, t, obs, exp_q[t-1]);
            else passed++;
            if (obs.fd && lat < 0) lat = t;
        end
        checks++;
        if (lat != want_lat) $display("[TB] FAIL %s_latency got=%0d want=%0d", name, lat, want_lat);
        else passed++;
        checks++;
        if (bus.timeout_err !== exp_timeout)
            $display("[TB] FAIL %s_timeout_err got=%b want=%b", name, bus.timeout_err, exp_timeout);
        else passed++;
        checks++;
        if (bus.overrun !== exp_overrun)
            $display("[TB] FAIL %s_overrun got=%b want=%b", name, bus.overrun, exp_overrun);
        else passed++;
    endtask

    task automatic check_all_zero(input string name);
        pix_t obs;
        obs = observe();
        checks++;
        if (obs !== '0) $display("[TB] FAIL %s_outputs got=%h want=0", name, obs);
        else passed++;
        checks++;
        if ({bus.timeout_err, bus.overrun} !== 2'b00)
            $display("[TB] FAIL %s_flags got=%b want=00", name, {bus.timeout_err, bus.overrun});
        else passed++;
    endtask

    task automatic test_reset();
        bus.enable = '1;
        bus.finish = '1;
        randomize_fields();
        drive_fields();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2;
        reset       = 1'b1;
        exp_timeout = 1'b0;
        exp_overrun = 1'b0;
    endtask

    task automatic test_full_frame();
        randomize_fields();
        set_delays(40);
        run_frame("full", 4'b1111, 4'b0000, 50, 329);
    endtask

    task automatic test_sparse_mask();
        randomize_fields();
        set_delays(40);
        run_frame("sparse", 4'b1010, 4'b0101, 10, 1 + 2*82);
    endtask

    task automatic test_pixel_mux();
        randomize_fields();
        sx[1] = 9'd309;
        sy[1] = 8'd5;
        sc[1] = 3'b101;
        set_delays(8);
        run_frame("pixel", 4'b0010, 4'b1111, 5, 1 + 18);
    endtask

    task automatic test_timeout_boundary();
        randomize_fields();
        set_delays(TO);
        run_frame("to_boundary", 4'b0001, 4'b0001, 0, 1 + 2*TO + 2);
    endtask

    task automatic test_timeout();
        randomize_fields();
        set_delays(5);
        fin_delay[2] = NEVER;
        run_frame("timeout", 4'b1111, 4'b1111, 0, 1 + 3*12 + 2*TO + 2);
    endtask

    task automatic test_enable_cleared();
        randomize_fields();
        set_delays(6);
        run_frame("en_cleared", 4'b0110, 4'b0000, 3, 1 + 2*14);
        run_frame("empty", 4'b0000, 4'b0000, 0, 1);
    endtask

    task automatic test_random_frames();
        logic [NS-1:0] m;
        int r;
        for (int f = 0; f < 6; f++) begin
            m = NS'($urandom);
            randomize_fields();
            for (int i = 0; i < NS; i++) begin
                r = $urandom_range(0, 9);
                fin_delay[i] = (r == 0) ? NEVER : (r == 1) ? TO : $urandom_range(1, 12);
            end
            run_frame("random", m, NS'($urandom), $urandom_range(1, 20), -1);
        end
    endtask

    task automatic test_reset_mid_draw();
        randomize_fields();
        set_delays(10);
        bus.enable = 4'b0010;
        drive_fields();
        wait_tick();
        // Sprite 1 alone: erase cycles 1..10, gap 11, draw 12..21.
        for (int t = 1; t <= 15; t++) begin
            @(posedge clk);
            #1;
            engine_step();
        end
        checks++;
        if (bus.draw_signal !== 4'b0010)
            $display("[TB] FAIL pre_reset_draw got=%b want=0010", bus.draw_signal);
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_draw");
        repeat (2) @(posedge clk);
        #3;
        reset       = 1'b1;
        exp_timeout = 1'b0;
        exp_overrun = 1'b0;
        for (int i = 0; i < NS; i++) req_cnt[i] = 0;
        run_frame("post_reset", 4'b0010, 4'b0010, 0, 1 + 2*10 + 2);
    endtask

    initial begin
        bus.enable        = '0;
        bus.finish        = '0;
        bus.sprite_x      = '0;
        bus.sprite_y      = '0;
        bus.sprite_colour = '0;
        for (int i = 0; i < NS; i++) req_cnt[i] = 0;
        test_reset();
        test_full_frame();
        test_sparse_mask();
        test_pixel_mux();
        test_timeout_boundary();
        test_timeout();
        test_enable_cleared();
        test_random_frames();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
